// File: rtl/frame_window_if.sv
// Bus bundle for frame_window: sample write port, window coefficient write
// port and the windowed-sample output burst.
interface frame_window_if #(
  parameter int FRAME_LEN = 256,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
);
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     coef_wr_en;
  logic        [IDX_W-1:0]  coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic signed [DATA_W-1:0] framed_out;
  logic                     framed_valid;
  logic                     frame_first;
  logic                     frame_last;
  logic                     overrun;

  modport master (
    output sample_in, sample_valid, coef_wr_en, coef_addr, coef_data,
    input  framed_out, framed_valid, frame_first, frame_last, overrun
  );

  modport slave (
    input  sample_in, sample_valid, coef_wr_en, coef_addr, coef_data,
    output framed_out, framed_valid, frame_first, frame_last, overrun
  );
endinterface

// File: rtl/frame_window.sv
// Slices a PCM stream into overlapping FRAME_LEN frames advanced by HOP and
// multiplies each frame by a programmable Q1.15 window, one sample per clock.
module frame_window #(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int BUF_DEPTH = 2*FRAME_LEN,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
) (
  input logic         clk,
  input logic         rst,
  frame_window_if.slave bus
);
  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int BUF_AW = $clog2(BUF_DEPTH);
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [PROD_W-1:0] prod);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sh;
    sum = {prod[PROD_W-1], prod} + SUM_W'(1 << (COEF_W-2));
    sh  = sum >>> (COEF_W-1);
    if (sh[SUM_W-1:DATA_W-1] == {(SUM_W-DATA_W+1){sh[SUM_W-1]}})
      round_sat = sh[DATA_W-1:0];
    else
      round_sat = sh[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  logic signed [DATA_W-1:0] sbuf     [BUF_DEPTH];
  logic signed [COEF_W-1:0] coef_ram [FRAME_LEN];

  state_t            state, state_nxt;
  logic [BUF_AW-1:0] wr_ptr, wr_ptr_inc, pend_base, rd_base, rd_addr_p0;
  logic [HOP_W-1:0]  hop_cnt;
  logic [IDX_W-1:0]  rd_idx;
  logic              first_done, pending, overrun_r, frame_ready;
  logic              load, rd_end, vld_p0, first_p0, last_p0;

  logic signed [DATA_W-1:0] sample_p1;
  logic signed [COEF_W-1:0] coef_p1;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1, first_p1, last_p1;

  logic signed [DATA_W-1:0] framed_p2;
  logic                     vld_p2, first_p2, last_p2;

  assign wr_ptr_inc  = wr_ptr + BUF_AW'(1);
  assign frame_ready = bus.sample_valid &&
                       (first_done ? (hop_cnt == HOP_W'(HOP-1))
                                   : (wr_ptr == BUF_AW'(FRAME_LEN-1)));

  always_ff @(posedge clk) begin
    if (bus.sample_valid) sbuf[wr_ptr] <= bus.sample_in;
    if (bus.coef_wr_en)   coef_ram[bus.coef_addr] <= bus.coef_data;
  end

  // A ready frame is accepted only into an empty pending slot; otherwise it is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      hop_cnt    <= '0;
      first_done <= 1'b0;
      pending    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        wr_ptr <= wr_ptr_inc;
        if (first_done)
          hop_cnt <= (hop_cnt == HOP_W'(HOP-1)) ? '0 : hop_cnt + HOP_W'(1);
      end
      if (frame_ready) first_done <= 1'b1;
      if (load)        pending    <= 1'b0;
      if (frame_ready) begin
        if (!pending) pending   <= 1'b1;
        else          overrun_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (frame_ready && !pending) pend_base <= wr_ptr_inc - BUF_AW'(FRAME_LEN);
    if (load)                    rd_base   <= pend_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_idx <= '0;
    end else begin
      state <= state_nxt;
      if (load)        rd_idx <= '0;
      else if (vld_p0) rd_idx <= rd_idx + IDX_W'(1);
    end
  end

  assign rd_end = (rd_idx == IDX_W'(FRAME_LEN-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending)            state_nxt = EMIT;
      EMIT:    if (rd_end && !pending) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    vld_p0   = 1'b0;
    first_p0 = 1'b0;
    last_p0  = 1'b0;
    case (state)
      IDLE: load = pending;
      EMIT: begin
        vld_p0   = 1'b1;
        load     = rd_end && pending;
        first_p0 = (rd_idx == '0);
        last_p0  = rd_end;
      end
      default: load = 1'b0;
    endcase
  end

  assign rd_addr_p0 = rd_base + BUF_AW'(rd_idx);

  // ---- p0 -> p1: RAM read data registered
  always_ff @(posedge clk) begin
    sample_p1 <= sbuf[rd_addr_p0];
    coef_p1   <= coef_ram[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
    end
  end

  assign prod_p1 = sample_p1 * coef_p1;

  // ---- p1 -> p2: windowed, rounded and saturated sample registered
  always_ff @(posedge clk) begin
    if (rst) begin
      framed_p2 <= '0;
      vld_p2    <= 1'b0;
      first_p2  <= 1'b0;
      last_p2   <= 1'b0;
    end else begin
      framed_p2 <= vld_p1 ? round_sat(prod_p1) : '0;
      vld_p2    <= vld_p1;
      first_p2  <= first_p1;
      last_p2   <= last_p1;
    end
  end

  assign bus.framed_out   = framed_p2;
  assign bus.framed_valid = vld_p2;
  assign bus.frame_first  = first_p2;
  assign bus.frame_last   = last_p2;
  assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_frame_window.sv
// Scoreboard bench for frame_window: directed frames pushed as expected
// bursts, popped and compared by an independent output monitor.
module tb_frame_window;
  localparam int FL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_window_if #(.FRAME_LEN(FL)) bus ();
  frame_window #(.FRAME_LEN(FL), .HOP(128)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic signed [15:0] v;
    bit                 first;
    bit                 last;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_out [0:1023];
  int   nsamp = 0;
  int   last_wcyc = 0;
  int   s1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.framed_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual %0d required no output (cycle %0d)",
                 bus.framed_out, cyc);
      end else begin
        e = sb.pop_front();
        check_int("framed_out", int'(bus.framed_out), int'(e.v));
        check_int("frame_first", int'(bus.frame_first), int'(e.first));
        check_int("frame_last", int'(bus.frame_last), int'(e.last));
        if (e.cyc >= 0) check_int("frame_start_cycle", cyc, e.cyc);
      end
    end
  end

  // Waits gap-1 idle cycles, then writes one sample; returns just after its edge.
  task automatic put_sample(input int v, input int e, input int gap);
    repeat (gap-1) begin
      @(posedge clk);
      #1;
    end
    bus.sample_in    = 16'(v);
    bus.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    last_wcyc        = cyc;
    bus.sample_valid = 1'b0;
    exp_out[nsamp]   = e;
    nsamp++;
  endtask

  task automatic push_frame(input int base, input int n, input int start_cyc);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v     = 16'(exp_out[base+i]);
      e.first = (i == 0);
      e.last  = (i == FL-1);
      e.cyc   = (i == 0) ? start_cyc : -1;
      sb.push_back(e);
    end
  endtask

  task automatic wr_coef(input int a, input int d);
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = 8'(a);
    bus.coef_data  = 16'(d);
    @(posedge clk);
    #1;
    bus.coef_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    nsamp = 0;
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check_int({tag, "_framed_out"}, int'(bus.framed_out), 0);
    check_int({tag, "_framed_valid"}, int'(bus.framed_valid), 0);
    check_int({tag, "_frame_first"}, int'(bus.frame_first), 0);
    check_int({tag, "_frame_last"}, int'(bus.frame_last), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check_int("drain_remaining", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv [6];
    int te [6];
    tv = '{-32768, 32767, 3, -3, 1, -1};
    te = '{32767, -32767, 2, -1, 1, 0};

    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.coef_wr_en   = 1'b0;
    bus.coef_addr    = '0;
    bus.coef_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_quiet("reset");
    check_int("reset_overrun", int'(bus.overrun), 0);

    // First frame, then a hop-overlapped second frame, unity-ish window.
    for (int a = 0; a < FL; a++) wr_coef(a, 'h7FFF);
    for (int k = 0; k < 256; k++) put_sample(k, k, 4);
    push_frame(0, 256, last_wcyc + 3);
    for (int k = 256; k < 384; k++) put_sample(k, k, 4);
    push_frame(128, 256, last_wcyc + 3);
    drain();
    check_int("hop_overrun", int'(bus.overrun), 0);

    // Reset while output index 100 of the third frame is on the bus.
    for (int k = 384; k < 512; k++) put_sample(k, k, 4);
    push_frame(256, 101, last_wcyc + 3);
    repeat (103) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    check_quiet("midrst");
    check_int("midrst_queue", sb.size(), 0);
    for (int k = 0; k < 256; k++) put_sample(1000 - 9*k, 1000 - 9*k, 2);
    push_frame(0, 256, last_wcyc + 3);
    drain();

    // Rounding and saturation.
    do_reset();
    wr_coef(0, 'h8000);
    wr_coef(1, 'h8000);
    for (int a = 2; a < FL; a++) wr_coef(a, 'h4000);
    for (int k = 0; k < 6; k++) put_sample(tv[k], te[k], 1);
    for (int k = 6; k < 256; k++) put_sample(0, 0, 1);
    push_frame(0, 256, last_wcyc + 3);
    drain();

    // Continuous input: third ready frame dropped, others back-to-back.
    do_reset();
    check_int("rst_overrun", int'(bus.overrun), 0);
    for (int a = 0; a < FL; a++) wr_coef(a, 'h7FFF);
    for (int k = 0; k < 640; k++) begin
      put_sample(k, k, 1);
      if (k == 255) begin
        s1 = last_wcyc + 3;
        push_frame(0, 256, s1);
      end
      if (k == 383) push_frame(128, 256, s1 + 256);
      if (k == 510) check_int("pre_drop_overrun", int'(bus.overrun), 0);
      if (k == 511) check_int("drop_overrun", int'(bus.overrun), 1);
      if (k == 639) push_frame(384, 256, s1 + 512);
    end
    drain();
    check_int("sticky_overrun", int'(bus.overrun), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_window.md
# frame_window

Framing and windowing stage directly upstream of the Goertzel DFT. It accepts a stream of 16-bit signed PCM samples and slices it into overlapping frames of `FRAME_LEN` samples advanced by `HOP`. Each frame is multiplied sample-by-sample by a programmable Q1.15 window. The result is a burst of `FRAME_LEN` windowed samples on `framed_out`/`framed_valid` at one sample per clock. The output has no backpressure, because the downstream DFT stage consumes every valid cycle.

## Interface
- `FRAME_LEN`, 256: samples per frame; power of two, ≥ 4.
- `HOP`, 128: new samples between successive frame starts; 1 ≤ `HOP` ≤ `FRAME_LEN`.
- `BUF_DEPTH`, 2*`FRAME_LEN`: circular sample buffer depth (power of two).

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sample_in` in 16: signed PCM sample.
- `sample_valid` in 1: `sample_in` is written to the buffer this cycle.
- `coef_wr_en` in 1: write the window coefficient RAM.
- `coef_addr` in log2(`FRAME_LEN`): coefficient index.
- `coef_data` in 16: signed Q1.15 window coefficient.
- `framed_out` out 16: signed windowed sample.
- `framed_valid` out 1: `framed_out` is valid.
- `frame_first` out 1: with `framed_valid`, marks sample index 0 of a frame.
- `frame_last` out 1: with `framed_valid`, marks sample index `FRAME_LEN`-1.
- `overrun` out 1: sticky flag; a ready frame was dropped.

## Operation
- **Reset.** All outputs go to 0. `wr_ptr`, `hop_cnt`, `first_done`, `pending` and `overrun` clear, and the FSM goes to IDLE. Neither buffer nor coefficient RAM contents are reset; coefficients must be written after power-up.
- **Write side.** On `sample_valid`, store the sample at `buf[wr_ptr]` and advance `wr_ptr` modulo `BUF_DEPTH`.
  - The first frame becomes ready on the write of the `FRAME_LEN`-th sample after reset (`first_done` then sets).
  - After that, a frame becomes ready on every `HOP`-th write, counted by `hop_cnt`, which wraps at `HOP`.
  - The ready frame's base is `wr_ptr_after_write - FRAME_LEN` (mod `BUF_DEPTH`).
- **Frame queue.** Holds one pending frame base in addition to the frame being emitted.
  - If a frame becomes ready while one is already pending, the new frame is dropped and `overrun` sets. `overrun` clears only on `rst`.
  - Without overrun, `BUF_DEPTH` = 2*`FRAME_LEN` guarantees that no emitted sample is overwritten before it is read.
- **FSM states.**
  - IDLE: if a frame is pending, load `rd_base`, clear `rd_idx`, clear `pending`, and go to EMIT.
  - EMIT: each cycle, issue a read of `buf[rd_base+rd_idx]` and `coef[rd_idx]`, then increment `rd_idx`.
  - At `rd_idx`=`FRAME_LEN`-1: if `pending`, reload the next frame and stay in EMIT, so frames go back-to-back with no gap. Otherwise go to IDLE.
  - A frame that becomes ready in the same cycle the FSM samples `pending` is seen one cycle later (no bypass).
- **Arithmetic.**
  - `prod` = `sample` (s16) × `coef` (s16), a 32-bit signed value.
  - `y` = (`prod` + 0x4000) >>> 15, an arithmetic shift with round-half-up.
  - `y` saturates to [−32768, 32767].
- **Coefficient writes.** A write during EMIT takes effect from the next cycle's read. The read/write same-address, same-cycle outcome is unspecified.
- **Simultaneous events.** A `sample_valid` write and an EMIT read in the same cycle are always legal.

## Timing
- Two-stage read pipeline:
  - Cycle N (issue): address the buffer and coefficient RAMs.
  - Cycle N+1: RAM data is registered.
  - Cycle N+2: `y` is registered onto `framed_out`, with `framed_valid`=1.
- Latency from the ready-making write (cycle t) to the first `framed_valid` (index 0, `frame_first`=1) is t+3 when starting from IDLE with nothing pending.
- A frame occupies exactly `FRAME_LEN` consecutive `framed_valid` cycles. `frame_first` and `frame_last` are single-cycle pulses.
- Reset mid-frame: the cycle after `rst`, all outputs are 0 and the pipeline is flushed, so no partial frame tail appears. Framing restarts from an empty buffer and needs a full `FRAME_LEN` samples again.
- Maximum sustained input rate with no overrun: one sample every `FRAME_LEN`/`HOP` cycles on average. For defaults, that is one sample every 2 cycles.

## Test plan
1. **First frame.** Defaults, coefficients all 0x7FFF, one sample per 4 cycles carrying values 0..255 → first `framed_valid` 3 cycles after sample 255's write. `framed_out` = round(k×32767/32768) = k for k = 0..255. `frame_first` falls on 0 and `frame_last` on 255.
2. **Hop overlap.** Continue with samples 256..383 → second frame outputs 128..383, with its start 3 cycles after sample 383's write. `overrun` stays 0.
3. **Rounding and sign.** Coefficient 0x4000 (0.5), samples 3, −3, 1, −1 → outputs 2, −1, 1, 0.
4. **Saturation.** Coefficient 0x8000 (−1.0), sample −32768 → 32767. The same coefficient with sample 32767 → −32767.
5. **Overrun.** `sample_valid` every cycle with `HOP`=128 → a third ready frame arrives while one is emitting and one is pending. It is dropped, `overrun`=1 sticky, and the emitted frames remain contiguous and correct.
6. **Reset mid-frame.** Assert `rst` for 1 cycle at output index 100 → next cycle `framed_valid`=0 and all outputs are 0. No output appears until 256 new samples arrive; the first post-reset frame equals those samples.
